// File: rtl/mem_lsu.sv
// ---------------------------------------------------------------------------
// mem_lsu -- memory-access stage behind the load/store execute unit.
//
// Purpose:
//   Captures one load/store request, runs it on a req/gnt/rvalid data bus with
//   byte enables and lane-replicated write data, and returns sign/zero-extended
//   load data on the writeback port. The upstream pipeline is stalled while a
//   transaction is outstanding. Bus errors and timeouts raise a one-cycle
//   exception pulse carrying the faulting byte address.
//
// Build option:
//   MISALIGN_TRAP_EN  defined   -> misaligned half/word accesses issue no bus
//                                  cycle and raise an exception instead.
//                     undefined -> misaligned addresses are force-aligned and
//                                  the access proceeds normally.
//
// Op encoding on mem_op_i:
//   0 NOP, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW (others ignored)
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), asynchronous active-low reset
//   valid_i, mem_op_i,
//   mem_we_i, mem_addr_i,
//   mem_data_i, rd_i        request from execute
//   stall_o                 hold execute stage and upstream
//   bus_req_o, bus_we_o,
//   bus_addr_o, bus_be_o,
//   bus_wdata_o             bus request channel (held until bus_gnt_i)
//   bus_gnt_i, bus_rvalid_i,
//   bus_rdata_i, bus_err_i  bus grant / response channel
//   wb_we_o, wb_rd_o,
//   wb_wdata_o              one-cycle load writeback
//   exc_o, exc_addr_o       one-cycle exception pulse and faulting address
// ---------------------------------------------------------------------------
module mem_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    input  logic [3:0]            mem_op_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic [4:0]            rd_i,
    output logic                  stall_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_gnt_i,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i,
    input  logic                  bus_err_i,
    output logic                  wb_we_o,
    output logic [4:0]            wb_rd_o,
    output logic [DATA_WIDTH-1:0] wb_wdata_o,
    output logic                  exc_o,
    output logic [ADDR_WIDTH-1:0] exc_addr_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // The 8-bit counter aborts on the cycle it would reach TIMEOUT_CYCLES.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t                  state_reg;
    logic [3:0]              op_reg;
    logic [1:0]              off_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [4:0]              rd_reg;
    logic                    store_reg;
    logic [7:0]              cnt_reg;

    // ---------------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------------
    logic                  dec_known;
    logic                  dec_store;
    logic [1:0]            dec_size;
    logic [1:0]            dec_off;
    logic [3:0]            dec_be;
    logic [DATA_WIDTH-1:0] dec_wdata;
    logic                  accept;

    always_comb begin
        dec_known = 1'b1;
        dec_store = 1'b0;
        dec_size  = SZ_WORD;
        case (mem_op_i)
            OP_LB, OP_LBU: dec_size = SZ_BYTE;
            OP_LH, OP_LHU: dec_size = SZ_HALF;
            OP_LW:         dec_size = SZ_WORD;
            OP_SB: begin
                dec_store = 1'b1;
                dec_size  = SZ_BYTE;
            end
            OP_SH: begin
                dec_store = 1'b1;
                dec_size  = SZ_HALF;
            end
            OP_SW: begin
                dec_store = 1'b1;
                dec_size  = SZ_WORD;
            end
            default: dec_known = 1'b0;  // NOP and unknown codes
        endcase
    end

    // Lane offset after force-alignment; in the trapping build misaligned
    // accesses never reach the bus, so the same offset serves both builds.
    always_comb begin
        case (dec_size)
            SZ_BYTE: begin
                dec_off   = mem_addr_i[1:0];
                dec_be    = 4'b0001 << dec_off;
                dec_wdata = {4{mem_data_i[7:0]}};
            end
            SZ_HALF: begin
                dec_off   = {mem_addr_i[1], 1'b0};
                dec_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                dec_wdata = {2{mem_data_i[15:0]}};
            end
            default: begin
                dec_off   = 2'b00;
                dec_be    = 4'hF;
                dec_wdata = mem_data_i;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic dec_misalign;
    assign dec_misalign = ((dec_size == SZ_HALF) && mem_addr_i[0]) ||
                          ((dec_size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00));
`endif

    // A request whose write flag contradicts its op class is malformed and is
    // treated like an unknown op.
    assign accept = (state_reg == IDLE) && valid_i && dec_known &&
                    (mem_we_i == dec_store);

    // RESP already returns to IDLE, so stall is released there and execute
    // presents its next request in the cycle after RESP.
    assign stall_o = rst_n_i &&
                     (accept || (state_reg == REQ) || (state_reg == WAIT));

    // ---------------------------------------------------------------------
    // Response handling
    // ---------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] load_extend(
        input logic [3:0]            op,
        input logic [1:0]            off,
        input logic [DATA_WIDTH-1:0] rdata
    );
        logic [DATA_WIDTH-1:0] r;
        r = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   load_extend = {{24{r[7]}}, r[7:0]};
            OP_LBU:  load_extend = {24'd0, r[7:0]};
            OP_LH:   load_extend = {{16{r[15]}}, r[15:0]};
            OP_LHU:  load_extend = {16'd0, r[15:0]};
            default: load_extend = r;
        endcase
    endfunction

    logic                  complete;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] load_data;

    // Grant and rvalid together in REQ complete the access in one step.
    assign complete    = bus_rvalid_i &&
                         (((state_reg == REQ) && bus_gnt_i) || (state_reg == WAIT));
    assign timeout_hit = ((state_reg == REQ) || (state_reg == WAIT)) &&
                         !complete && (cnt_reg == TIMEOUT_LAST);
    assign load_data   = load_extend(op_reg, off_reg, bus_rdata_i);

    // ---------------------------------------------------------------------
    // FSM with registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= IDLE;
            op_reg      <= '0;
            off_reg     <= '0;
            addr_reg    <= '0;
            rd_reg      <= '0;
            store_reg   <= 1'b0;
            cnt_reg     <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            wb_we_o     <= 1'b0;
            wb_rd_o     <= '0;
            wb_wdata_o  <= '0;
            exc_o       <= 1'b0;
            exc_addr_o  <= '0;
        end else begin
            wb_we_o <= 1'b0;
            exc_o   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg    <= mem_op_i;
                        off_reg   <= dec_off;
                        addr_reg  <= mem_addr_i;
                        rd_reg    <= rd_i;
                        store_reg <= dec_store;
                        cnt_reg   <= '0;
`ifdef MISALIGN_TRAP_EN
                        if (dec_misalign) begin
                            state_reg  <= RESP;
                            exc_o      <= 1'b1;
                            exc_addr_o <= mem_addr_i;
                        end else
`endif
                        begin
                            state_reg   <= REQ;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= dec_store;
                            bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            bus_be_o    <= dec_be;
                            bus_wdata_o <= dec_wdata;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (complete || timeout_hit) begin
                        state_reg <= RESP;
                        bus_req_o <= 1'b0;
                        if (timeout_hit || bus_err_i) begin
                            exc_o      <= 1'b1;
                            exc_addr_o <= addr_reg;
                        end else if (!store_reg) begin
                            wb_we_o    <= 1'b1;
                            wb_rd_o    <= rd_reg;
                            wb_wdata_o <= load_data;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                        if ((state_reg == REQ) && bus_gnt_i) begin
                            state_reg <= WAIT;
                            bus_req_o <= 1'b0;
                        end
                    end
                end
                RESP:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_mem_lsu -- self-checking bench for mem_lsu.
// Expected bus requests, writebacks and exceptions are pushed to scoreboard
// queues when a request is driven; a negedge monitor pops and compares them
// as the DUT produces them. Honours MISALIGN_TRAP_EN like the design.
// ---------------------------------------------------------------------------
module tb_mem_lsu;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam int         TIMEOUT = 255;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic [3:0]  mem_op_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;
    logic        wb_we_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_wdata_o;
    logic        exc_o;
    logic [31:0] exc_addr_o;

    always #5 clk_i = ~clk_i;

    mem_lsu dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .valid_i      (valid_i),
        .mem_op_i     (mem_op_i),
        .mem_we_i     (mem_we_i),
        .mem_addr_i   (mem_addr_i),
        .mem_data_i   (mem_data_i),
        .rd_i         (rd_i),
        .stall_o      (stall_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i),
        .wb_we_o      (wb_we_o),
        .wb_rd_o      (wb_rd_o),
        .wb_wdata_o   (wb_wdata_o),
        .exc_o        (exc_o),
        .exc_addr_o   (exc_addr_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    bus_exp_t    exp_bus_q[$];
    wb_exp_t     exp_wb_q[$];
    logic [31:0] exp_exc_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    int          acc_cyc;
    int          wb_cyc;
    int          req_cycles;
    int          n_req = 0;
    int          n_wb = 0;
    int          n_exc = 0;
    logic        req_prev = 1'b0;
    logic [31:0] last_bus_addr;
    logic [3:0]  last_be;
    logic        last_we;
    logic [31:0] last_wdata;
    logic [31:0] last_wb_data;
    logic [31:0] last_exc_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    always @(posedge clk_i) cyc++;

    // Monitor: one line per observed transaction, scoreboard compare.
    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            req_prev = 1'b0;
        end else begin
            if (bus_req_o && !req_prev) begin
                bus_exp_t e;
                n_req++;
                last_bus_addr = bus_addr_o;
                last_be       = bus_be_o;
                last_we       = bus_we_o;
                last_wdata    = bus_wdata_o;
                $display("bus  addr=%08h be=%b we=%b wdata=%08h", bus_addr_o, bus_be_o, bus_we_o, bus_wdata_o);
                if (exp_bus_q.size() == 0) begin
                    check("bus_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_bus_q.pop_front();
                    check("bus_addr", bus_addr_o, e.addr);
                    check("bus_be", {28'd0, bus_be_o}, {28'd0, e.be});
                    check("bus_we", {31'd0, bus_we_o}, {31'd0, e.we});
                    if (e.we) check("bus_wdata", bus_wdata_o, e.wdata);
                end
            end
            req_prev = bus_req_o;
            if (wb_we_o) begin
                wb_exp_t w;
                n_wb++;
                wb_cyc       = cyc;
                last_wb_data = wb_wdata_o;
                $display("wb   rd=%0d data=%08h", wb_rd_o, wb_wdata_o);
                if (exp_wb_q.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    w = exp_wb_q.pop_front();
                    check("wb_rd", {27'd0, wb_rd_o}, {27'd0, w.rd});
                    check("wb_data", wb_wdata_o, w.data);
                end
            end
            if (exc_o) begin
                n_exc++;
                last_exc_addr = exc_addr_o;
                $display("exc  addr=%08h", exc_addr_o);
                if (exp_exc_q.size() == 0) check("exc_unexpected", 32'd1, 32'd0);
                else check("exc_addr", exc_addr_o, exp_exc_q.pop_front());
            end
        end
    end

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            default:              return 2'd2;
        endcase
    endfunction

    // Drive one request, model its expected effects, and act as the bus slave.
    // gnt_wait >= TIMEOUT means the grant never comes.
    task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input logic [31:0] rdata, input logic err,
                           input int gnt_wait, input int rv_wait, input bit combined);
        logic [1:0]  sz;
        logic        st;
        logic        trapped;
        logic [1:0]  off;
        logic [31:0] r;
        bus_exp_t    b;
        wb_exp_t     w;
        int          phase;
        int          waited;
        bit          done;

        sz      = op_size(op);
        st      = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        trapped = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trapped = ((sz == 2'd1) && addr[0]) || ((sz == 2'd2) && (addr[1:0] != 2'b00));
`endif
        b.addr = {addr[31:2], 2'b00};
        b.we   = st;
        case (sz)
            2'd0: begin
                off = addr[1:0];
                b.be = 4'b0001 << off;
                b.wdata = {4{data[7:0]}};
            end
            2'd1: begin
                off = {addr[1], 1'b0};
                b.be = addr[1] ? 4'b1100 : 4'b0011;
                b.wdata = {2{data[15:0]}};
            end
            default: begin
                off = 2'b00;
                b.be = 4'hF;
                b.wdata = data;
            end
        endcase
        r = rdata >> (8 * off);
        case (op)
            OP_LB:   w.data = {{24{r[7]}}, r[7:0]};
            OP_LBU:  w.data = {24'd0, r[7:0]};
            OP_LH:   w.data = {{16{r[15]}}, r[15:0]};
            OP_LHU:  w.data = {16'd0, r[15:0]};
            default: w.data = r;
        endcase
        w.rd = rd;

        if (trapped) begin
            exp_exc_q.push_back(addr);
        end else begin
            exp_bus_q.push_back(b);
            if (gnt_wait >= TIMEOUT || err) exp_exc_q.push_back(addr);
            else if (!st) exp_wb_q.push_back(w);
        end

        @(posedge clk_i); #1;
        valid_i    = 1'b1;
        mem_op_i   = op;
        mem_we_i   = st;
        mem_addr_i = addr;
        mem_data_i = data;
        rd_i       = rd;
        acc_cyc    = cyc;
        #1 check("accept_stall", {31'd0, stall_o}, 32'd1);

        phase = 1; waited = 0; done = 0; req_cycles = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk_i); #1;
            valid_i      = 1'b0;
            bus_gnt_i    = 1'b0;
            bus_rvalid_i = 1'b0;
            bus_err_i    = 1'b0;
            bus_rdata_i  = $urandom;
            if (bus_req_o) req_cycles++;
            if (!stall_o) begin
                done = 1;
            end else if (phase == 1) begin
                if (bus_req_o && waited >= gnt_wait) begin
                    bus_gnt_i = 1'b1;
                    waited    = 0;
                    if (combined) begin
                        bus_rvalid_i = 1'b1;
                        bus_rdata_i  = rdata;
                        bus_err_i    = err;
                        phase        = 3;
                    end else begin
                        phase = 2;
                    end
                end else begin
                    waited++;
                end
            end else if (phase == 2) begin
                if (waited >= rv_wait) begin
                    bus_rvalid_i = 1'b1;
                    bus_rdata_i  = rdata;
                    bus_err_i    = err;
                    phase        = 3;
                end else begin
                    waited++;
                end
            end
        end
        if (!done) check("txn_bound", 32'd0, 32'd1);
        @(negedge clk_i); #1;
    endtask

    logic [3:0] op_tab[8];
    int         wb_before;
    int         req_before;

    initial begin
        op_tab = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
        rst_n_i = 1'b0; valid_i = 1'b0; mem_op_i = OP_NOP; mem_we_i = 1'b0;
        mem_addr_i = '0; mem_data_i = '0; rd_i = '0;
        bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;

        // Reset state
        #12;
        check("reset_outs_zero", {31'd0, |{stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o,
              bus_wdata_o, wb_we_o, wb_rd_o, wb_wdata_o, exc_o, exc_addr_o}}, 32'd0);
        @(posedge clk_i); #1 rst_n_i = 1'b1;

        // LW, best-case latency
        run_txn(OP_LW, 32'h1000, 32'h0, 5'd3, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0);
        check("lw_data", last_wb_data, 32'hDEADBEEF);
        check("lw_be", {28'd0, last_be}, 32'hF);
        check("lw_latency", wb_cyc - acc_cyc, 32'd3);

        // LB / LBU from the top lane
        run_txn(OP_LB, 32'h1003, 32'h0, 5'd4, 32'h80112233, 1'b0, 1, 2, 1'b0);
        check("lb_be", {28'd0, last_be}, 32'h8);
        check("lb_data", last_wb_data, 32'hFFFFFF80);
        run_txn(OP_LBU, 32'h1003, 32'h0, 5'd5, 32'h80112233, 1'b0, 0, 1, 1'b0);
        check("lbu_data", last_wb_data, 32'h00000080);

        // SH, upper half, no writeback
        wb_before = n_wb;
        run_txn(OP_SH, 32'h2002, 32'h0000ABCD, 5'd6, 32'h0, 1'b0, 0, 0, 1'b0);
        check("sh_be", {28'd0, last_be}, 32'hC);
        check("sh_wdata", last_wdata, 32'hABCDABCD);
        check("sh_we", {31'd0, last_we}, 32'd1);
        check("sh_no_wb", n_wb, wb_before);

        // Grant and rvalid in the same REQ cycle
        run_txn(OP_LH, 32'h4002, 32'h0, 5'd7, 32'h80011234, 1'b0, 2, 0, 1'b1);
        check("lh_comb_data", last_wb_data, 32'hFFFF8001);

        // Bus error on a load and on a store
        run_txn(OP_LW, 32'h6000, 32'h0, 5'd8, 32'h11111111, 1'b1, 0, 3, 1'b0);
        check("lw_err_addr", last_exc_addr, 32'h6000);
        run_txn(OP_SW, 32'h6004, 32'h55AA55AA, 5'd0, 32'h0, 1'b1, 1, 0, 1'b1);
        check("sw_err_addr", last_exc_addr, 32'h6004);

        // Timeout with no grant
        run_txn(OP_LW, 32'h7000, 32'h0, 5'd9, 32'h0, 1'b0, 1000, 0, 1'b0);
        check("timeout_req_cycles", req_cycles, TIMEOUT);
        check("timeout_exc_addr", last_exc_addr, 32'h7000);
        check("timeout_stall_clear", {31'd0, stall_o}, 32'd0);

        // Late rvalid in IDLE is ignored
        wb_before = n_wb;
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b0;
        @(negedge clk_i); #1;
        check("late_rvalid_stall", {31'd0, stall_o}, 32'd0);
        check("late_rvalid_no_wb", n_wb, wb_before);

        // NOP and unknown op are ignored
        req_before = n_req;
        @(posedge clk_i); #1;
        valid_i = 1'b1; mem_op_i = OP_NOP; mem_we_i = 1'b0; mem_addr_i = 32'h8000;
        #1 check("nop_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        mem_op_i = 4'hC;
        #1 check("unknown_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(negedge clk_i); #1;
        check("nop_no_req", n_req, req_before);

        // Misaligned half
        req_before = n_req;
        run_txn(OP_LH, 32'h3001, 32'h0, 5'd10, 32'h0000BEEF, 1'b0, 0, 0, 1'b0);
`ifdef MISALIGN_TRAP_EN
        check("mis_no_req", n_req, req_before);
        check("mis_exc_addr", last_exc_addr, 32'h3001);
`else
        check("mis_bus_addr", last_bus_addr, 32'h3000);
        check("mis_be", {28'd0, last_be}, 32'h3);
`endif

        // Reset during WAIT
        begin
            bus_exp_t e;
            e.addr = 32'h5000; e.be = 4'hF; e.we = 1'b0; e.wdata = '0;
            exp_bus_q.push_back(e);
        end
        @(posedge clk_i); #1;
        valid_i = 1'b1; mem_op_i = OP_LW; mem_we_i = 1'b0; mem_addr_i = 32'h5000; rd_i = 5'd11;
        @(posedge clk_i); #1;
        valid_i = 1'b0; bus_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        bus_gnt_i = 1'b0;
        check("wait_stall", {31'd0, stall_o}, 32'd1);
        rst_n_i = 1'b0;
        #1 check("rst_mid_outs_zero", {31'd0, |{stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_be_o,
              bus_wdata_o, wb_we_o, wb_rd_o, wb_wdata_o, exc_o, exc_addr_o}}, 32'd0);
        @(posedge clk_i); @(posedge clk_i); #1 rst_n_i = 1'b1;
        run_txn(OP_LW, 32'h5004, 32'h0, 5'd12, 32'h12345678, 1'b0, 0, 0, 1'b0);
        check("post_rst_lw", last_wb_data, 32'h12345678);

        // Random mix with random handshake delays
        for (int k = 0; k < 24; k++) begin
            logic [3:0] op;
            op = op_tab[$urandom_range(0, 7)];
            run_txn(op, $urandom & 32'h0000FFFF, $urandom, 5'($urandom_range(1, 31)), $urandom,
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
        end

        @(posedge clk_i); @(negedge clk_i);
        check("sb_bus_left", exp_bus_q.size(), 32'd0);
        check("sb_wb_left", exp_wb_q.size(), 32'd0);
        check("sb_exc_left", exp_exc_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
